// File: rtl/mac_job_sequencer.sv
// Job sequencer for the MAC engine: latches a job config, steps engine and streamers row by row, pulses done.
// Optional RUN watchdog (adds TIMEOUT_CYC parameter and err_o) enabled by MAC_JOB_SEQUENCER_WATCHDOG_EN.
module mac_job_sequencer #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned ROW_W       = 16,
  parameter int unsigned SHIFT_W     = 6
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               trigger_i,
  input  logic               cfg_simple_mul_i,
  input  logic [CNT_W-1:0]   cfg_len_i,
  input  logic [SHIFT_W-1:0] cfg_shift_i,
  input  logic [ROW_W-1:0]   cfg_rows_i,
  input  logic               strm_idle_i,
  input  logic               d_valid_i,
  input  logic               d_ready_i,
  output logic               eng_clear_o,
  output logic               eng_enable_o,
  output logic               eng_start_o,
  output logic               eng_simple_mul_o,
  output logic [CNT_W-1:0]   eng_len_o,
  output logic [SHIFT_W-1:0] eng_shift_o,
  output logic               strm_req_o,
  output logic [CNT_W-1:0]   strm_ab_len_o,
  output logic [CNT_W-1:0]   strm_d_len_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [ROW_W-1:0]   rows_done_o
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
  ,
  output logic               err_o
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, ROW_END, DONE} state_e;

  state_e             state_q, state_d;
  logic               simple_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   d_len_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [ROW_W-1:0]   rows_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   rows_done_q, rows_done_d;
  logic               latch_cfg;
  logic               hs;

  assign hs = d_valid_i & d_ready_i;

`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            timeout;

  // Fires on the TIMEOUT_CYC-th consecutive RUN cycle without an output handshake
  assign timeout = (state_q == RUN) && !hs && (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign err_o   = err_q;
`endif

  // Next-state, counter updates and single-cycle strobes
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rows_done_d = rows_done_q;
    latch_cfg   = 1'b0;
    eng_clear_o = 1'b0;
    eng_start_o = 1'b0;
    strm_req_o  = 1'b0;
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
    wd_d        = wd_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (trigger_i && strm_idle_i) begin
          latch_cfg   = 1'b1;
          rows_done_d = '0;
          state_d     = LOAD;
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
          err_d       = 1'b0;
`endif
        end
      end
      LOAD: begin
        eng_clear_o = 1'b1;
        if ((len_q == '0) || (!simple_q && (rows_q == '0))) state_d = DONE;
        else                                                state_d = START;
      end
      START: begin
        if (strm_idle_i) begin
          eng_start_o = 1'b1;
          strm_req_o  = 1'b1;
          cnt_d       = '0;
          state_d     = RUN;
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
          wd_d        = '0;
`endif
        end
      end
      RUN: begin
        if (hs) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!simple_q)           state_d = ROW_END;
          else if (cnt_d == len_q) state_d = DONE;
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
          wd_d  = '0;
`endif
        end
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
        else if (timeout) begin
          eng_clear_o = 1'b1;
          err_d       = 1'b1;
          state_d     = DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      ROW_END: begin
        rows_done_d = rows_done_q + ROW_W'(1);
        state_d     = (rows_done_d == rows_q) ? DONE : START;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Soft clear aborts the job from any state without a done pulse
    if (clear_i) begin
      state_d     = IDLE;
      eng_clear_o = 1'b1;
      cnt_d       = '0;
      rows_done_d = '0;
      latch_cfg   = 1'b0;
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
      wd_d        = '0;
      err_d       = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      simple_q    <= 1'b0;
      len_q       <= '0;
      d_len_q     <= '0;
      shift_q     <= '0;
      rows_q      <= '0;
      cnt_q       <= '0;
      rows_done_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rows_done_q <= rows_done_d;
      if (clear_i) begin
        simple_q <= 1'b0;
        len_q    <= '0;
        d_len_q  <= '0;
        shift_q  <= '0;
        rows_q   <= '0;
      end else if (latch_cfg) begin
        simple_q <= cfg_simple_mul_i;
        len_q    <= cfg_len_i;
        d_len_q  <= cfg_simple_mul_i ? cfg_len_i : CNT_W'(1);
        shift_q  <= cfg_shift_i;
        rows_q   <= cfg_rows_i;
      end
    end
  end

`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`endif

  assign busy_o           = (state_q != IDLE);
  assign eng_enable_o     = busy_o;
  assign done_o           = (state_q == DONE);
  assign eng_simple_mul_o = simple_q;
  assign eng_len_o        = len_q;
  assign eng_shift_o      = shift_q;
  assign strm_ab_len_o    = len_q;
  assign strm_d_len_o     = d_len_q;
  assign rows_done_o      = rows_done_q;

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Self-checking bench for mac_job_sequencer: scoreboard of expected streamer requests and done events.
// Watchdog scenario is compiled in with MAC_JOB_SEQUENCER_WATCHDOG_EN.
module tb_mac_job_sequencer;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ROW_W   = 16;
  localparam int unsigned SHIFT_W = 6;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               clear_i = 1'b0;
  logic               trigger_i = 1'b0;
  logic               cfg_simple_mul_i = 1'b0;
  logic [CNT_W-1:0]   cfg_len_i = '0;
  logic [SHIFT_W-1:0] cfg_shift_i = '0;
  logic [ROW_W-1:0]   cfg_rows_i = '0;
  logic               strm_idle_i = 1'b1;
  logic               d_valid_i = 1'b0;
  logic               d_ready_i = 1'b0;
  logic               eng_clear_o, eng_enable_o, eng_start_o, eng_simple_mul_o;
  logic [CNT_W-1:0]   eng_len_o, strm_ab_len_o, strm_d_len_o;
  logic [SHIFT_W-1:0] eng_shift_o;
  logic               strm_req_o, busy_o, done_o;
  logic [ROW_W-1:0]   rows_done_o;
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
  logic               err_o;
`endif

  mac_job_sequencer #(
    .CNT_W(CNT_W), .ROW_W(ROW_W), .SHIFT_W(SHIFT_W)
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .trigger_i(trigger_i),
    .cfg_simple_mul_i(cfg_simple_mul_i), .cfg_len_i(cfg_len_i), .cfg_shift_i(cfg_shift_i),
    .cfg_rows_i(cfg_rows_i), .strm_idle_i(strm_idle_i), .d_valid_i(d_valid_i), .d_ready_i(d_ready_i),
    .eng_clear_o(eng_clear_o), .eng_enable_o(eng_enable_o), .eng_start_o(eng_start_o),
    .eng_simple_mul_o(eng_simple_mul_o), .eng_len_o(eng_len_o), .eng_shift_o(eng_shift_o),
    .strm_req_o(strm_req_o), .strm_ab_len_o(strm_ab_len_o), .strm_d_len_o(strm_d_len_o),
    .busy_o(busy_o), .done_o(done_o), .rows_done_o(rows_done_o)
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic             is_done;
    logic [CNT_W-1:0] ab;
    logic [CNT_W-1:0] dl;
    logic [ROW_W-1:0] rows;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Results of the last run_job call
  int r_n_req, r_req_cyc, r_n_done, r_done_cyc, r_n_hs, r_last_hs, r_n_clear, r_first_clr;
  int r_start_mis, r_busy_after, r_rows_after, r_rows_at_done, r_clr_same, r_timed_out;
  int r_simple_ok, r_len, r_shift, r_err_at_done, r_err_at_load;

  task automatic push_req(input int ab, input int dl);
    exp_q.push_back('{1'b0, CNT_W'(ab), CNT_W'(dl), ROW_W'(0)});
  endtask

  task automatic push_done(input int rows);
    exp_q.push_back('{1'b1, CNT_W'(0), CNT_W'(0), ROW_W'(rows)});
  endtask

  task automatic set_cfg(input bit simple, input int len, input int shift, input int rows);
    cfg_simple_mul_i = simple;
    cfg_len_i        = CNT_W'(len);
    cfg_shift_i      = SHIFT_W'(shift);
    cfg_rows_i       = ROW_W'(rows);
  endtask

  // Drives one job from its trigger (cycle 0) with a simple engine model; scoreboards req/done events.
  task automatic run_job(input int budget, input int per_req, input bit tog,
                         input int idle_lo_from, input int idle_lo_to, input int trig2_at, input int clr_req);
    int   pend, clr_cyc, stop_at;
    exp_t e;
    pend = 0; clr_cyc = -1; stop_at = -1;
    r_n_req = 0; r_req_cyc = -1; r_n_done = 0; r_done_cyc = -1; r_n_hs = 0; r_last_hs = -100;
    r_n_clear = 0; r_first_clr = -1; r_start_mis = 0; r_busy_after = -1; r_rows_after = -1;
    r_rows_at_done = -1; r_clr_same = 0; r_timed_out = 1; r_simple_ok = 1; r_len = -1; r_shift = -1;
    r_err_at_done = -1; r_err_at_load = -1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk_i); #1;
      trigger_i   = (c == 0) || (c == trig2_at);
      strm_idle_i = !(c >= idle_lo_from && c <= idle_lo_to);
      d_ready_i   = tog ? c[0] : 1'b1;
      clear_i     = (c == clr_cyc);
      if (clear_i) pend = 0;
      d_valid_i   = (pend > 0);
      @(negedge clk_i);
      if (eng_clear_o) begin
        r_n_clear++;
        if (r_req_cyc >= 0 && r_first_clr < 0) r_first_clr = c;
      end
      if (clear_i) begin r_clr_same = eng_clear_o; stop_at = c + 1; end
      if (eng_start_o !== strm_req_o) r_start_mis++;
      if (busy_o && !eng_simple_mul_o) r_simple_ok = 0;
      if (d_valid_i && d_ready_i) begin r_n_hs++; r_last_hs = c; pend--; end
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
      if (c == 1) r_err_at_load = err_o;
`endif
      if (strm_req_o) begin
        r_n_req++;
        if (r_req_cyc < 0) begin r_req_cyc = c; r_len = eng_len_o; r_shift = eng_shift_o; end
        pend += per_req;
        if (r_n_req == clr_req) clr_cyc = c + 1;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL sb_req unexpected strm_req_o at cycle %0d", c);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done !== 1'b0 || strm_ab_len_o !== e.ab || strm_d_len_o !== e.dl) begin
            failures++;
            $display("FAIL sb_req got req ab=%0d d=%0d exp is_done=%0d ab=%0d d=%0d",
                     strm_ab_len_o, strm_d_len_o, e.is_done, e.ab, e.dl);
          end
        end
      end
      if (done_o) begin
        r_n_done++; r_done_cyc = c; r_rows_at_done = rows_done_o; stop_at = c + 1;
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
        r_err_at_done = err_o;
`endif
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL sb_done unexpected done_o at cycle %0d", c);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done !== 1'b1 || rows_done_o !== e.rows) begin
            failures++;
            $display("FAIL sb_done got done rows=%0d exp is_done=%0d rows=%0d", rows_done_o, e.is_done, e.rows);
          end
        end
      end
      if (c == stop_at) begin
        r_busy_after = busy_o; r_rows_after = rows_done_o; r_timed_out = 0;
        break;
      end
    end
    @(posedge clk_i); #1;
    trigger_i = 1'b0; clear_i = 1'b0; d_valid_i = 1'b0; strm_idle_i = 1'b1;
    checks++;
    if (r_timed_out != 0) begin failures++; $display("FAIL job_timeout got=timeout exp=completion"); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d pending exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++;
    if ({eng_clear_o, eng_enable_o, eng_start_o, eng_simple_mul_o, eng_len_o, eng_shift_o, strm_req_o,
         strm_ab_len_o, strm_d_len_o, busy_o, done_o, rows_done_o} !== '0) begin
      failures++; $display("FAIL reset_outputs got busy=%0d d_len=%0d rows=%0d exp all zero", busy_o, strm_d_len_o, rows_done_o);
    end
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
    checks++;
    if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_o); end
`endif
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_scalar();
    set_cfg(1'b0, 4, 5, 3);
    for (int i = 0; i < 3; i++) push_req(4, 1);
    push_done(3);
    run_job(200, 1, 1'b0, -1, -2, -1, 0);
    checks++; if (r_n_req != 3) begin failures++; $display("FAIL scalar_reqs got=%0d exp=3", r_n_req); end
    checks++; if (r_start_mis != 0) begin failures++; $display("FAIL scalar_start_eq_req got=%0d exp=0", r_start_mis); end
    checks++; if (r_n_done != 1) begin failures++; $display("FAIL scalar_done_cnt got=%0d exp=1", r_n_done); end
    checks++; if (r_rows_at_done != 3) begin failures++; $display("FAIL scalar_rows got=%0d exp=3", r_rows_at_done); end
    checks++; if (r_busy_after != 0) begin failures++; $display("FAIL scalar_busy_after got=%0d exp=0", r_busy_after); end
    checks++; if (r_len != 4 || r_shift != 5) begin failures++; $display("FAIL scalar_cfg got len=%0d shift=%0d exp 4 5", r_len, r_shift); end
    checks++; if (r_n_clear != 1) begin failures++; $display("FAIL scalar_clear_cnt got=%0d exp=1", r_n_clear); end
    checks++; if (r_done_cyc != 11) begin failures++; $display("FAIL scalar_done_cyc got=%0d exp=11", r_done_cyc); end
  endtask

  task automatic test_simple();
    set_cfg(1'b1, 8, 3, 0);
    push_req(8, 8);
    push_done(0);
    run_job(200, 8, 1'b1, -1, -2, -1, 0);
    checks++; if (r_n_req != 1) begin failures++; $display("FAIL simple_reqs got=%0d exp=1", r_n_req); end
    checks++; if (r_n_hs != 8) begin failures++; $display("FAIL simple_hs got=%0d exp=8", r_n_hs); end
    checks++; if (r_done_cyc != r_last_hs + 1) begin failures++; $display("FAIL simple_done_lat got=%0d exp=%0d", r_done_cyc, r_last_hs + 1); end
    checks++; if (r_simple_ok != 1) begin failures++; $display("FAIL simple_mul_held got=%0d exp=1", r_simple_ok); end
    checks++; if (r_busy_after != 0) begin failures++; $display("FAIL simple_busy_after got=%0d exp=0", r_busy_after); end
  endtask

  task automatic test_zero_len();
    set_cfg(1'b0, 0, 1, 3);
    push_done(0);
    run_job(50, 1, 1'b0, -1, -2, -1, 0);
    checks++; if (r_done_cyc != 2) begin failures++; $display("FAIL zero_done_cyc got=%0d exp=2", r_done_cyc); end
    checks++; if (r_n_req != 0) begin failures++; $display("FAIL zero_reqs got=%0d exp=0", r_n_req); end
    checks++; if (r_n_clear != 1) begin failures++; $display("FAIL zero_clear_cnt got=%0d exp=1", r_n_clear); end
  endtask

  task automatic test_clear();
    set_cfg(1'b0, 3, 2, 5);
    push_req(3, 1); push_req(3, 1);
    run_job(200, 1, 1'b0, -1, -2, -1, 2);
    checks++; if (r_clr_same != 1) begin failures++; $display("FAIL clear_same_cycle got=%0d exp=1", r_clr_same); end
    checks++; if (r_busy_after != 0) begin failures++; $display("FAIL clear_idle_next got busy=%0d exp=0", r_busy_after); end
    checks++; if (r_rows_after != 0) begin failures++; $display("FAIL clear_rows got=%0d exp=0", r_rows_after); end
    checks++; if (r_n_done != 0) begin failures++; $display("FAIL clear_no_done got=%0d exp=0", r_n_done); end
    set_cfg(1'b0, 2, 0, 2);
    push_req(2, 1); push_req(2, 1); push_done(2);
    run_job(200, 1, 1'b0, -1, -2, -1, 0);
    checks++; if (r_n_done != 1 || r_rows_at_done != 2) begin failures++; $display("FAIL clear_rerun got done=%0d rows=%0d exp 1 2", r_n_done, r_rows_at_done); end
  endtask

  task automatic test_idle_hold();
    set_cfg(1'b1, 3, 7, 9);
    push_req(3, 3);
    push_done(0);
    run_job(200, 3, 1'b0, 1, 6, 9, 0);
    checks++; if (r_req_cyc != 7) begin failures++; $display("FAIL idle_req_cyc got=%0d exp=7", r_req_cyc); end
    checks++; if (r_n_req != 1) begin failures++; $display("FAIL idle_reqs got=%0d exp=1", r_n_req); end
    checks++; if (r_done_cyc != 11) begin failures++; $display("FAIL idle_done_cyc got=%0d exp=11", r_done_cyc); end
    checks++; if (r_busy_after != 0) begin failures++; $display("FAIL retrigger_ignored got busy=%0d exp=0", r_busy_after); end
  endtask

`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
  task automatic test_watchdog();
    set_cfg(1'b1, 4, 0, 0);
    push_req(4, 4);
    push_done(0);
    run_job(200, 0, 1'b0, -1, -2, -1, 0);
    checks++; if (r_first_clr != r_req_cyc + 16) begin failures++; $display("FAIL wd_clear_cyc got=%0d exp=%0d", r_first_clr, r_req_cyc + 16); end
    checks++; if (r_n_clear != 2) begin failures++; $display("FAIL wd_clear_cnt got=%0d exp=2", r_n_clear); end
    checks++; if (r_err_at_done != 1) begin failures++; $display("FAIL wd_err got=%0d exp=1", r_err_at_done); end
    checks++; if (r_done_cyc != 19) begin failures++; $display("FAIL wd_done_cyc got=%0d exp=19", r_done_cyc); end
    set_cfg(1'b1, 0, 0, 0);
    push_done(0);
    run_job(50, 0, 1'b0, -1, -2, -1, 0);
    checks++; if (r_err_at_load != 0) begin failures++; $display("FAIL wd_err_cleared got=%0d exp=0", r_err_at_load); end
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk_i);
    test_reset();
    test_scalar();
    test_simple();
    test_zero_len();
    test_clear();
    test_idle_hold();
`ifdef MAC_JOB_SEQUENCER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
